feed_cycle_ctrl: RTL

FEED_CYCLE_CTRL -- requirements
Module: feed_cycle_ctrl

---
 rtl/feed_cycle_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/feed_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : feed_cycle_ctrl
// Description : Card-feed cycle controller. Drives the clutch latch magnet
//               so that the clutched shaft makes one revolution per feed
//               request. It emits one row strobe per row-emitter contact,
//               checks the row count at the end of each revolution, and
//               chains back-to-back revolutions while feeding is still
//               requested.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   NONSYNC_EN  defined   : clutch may engage at continuous angles 75, 195, 315
//               undefined : clutch engages at continuous angle 315 only
// ----------------------------------------------------------------------------
// Parameters:
//   ARM_WINDOW  missed engagement points tolerated in ARM before fault
//   ROWS        row-emitter pulses expected per clutched revolution
// Ports:
//   clk            in   1   system clock, one shaft degree per cycle
//   reset          in   1   synchronous active-high reset
//   i_cont_angle   in   9   continuous shaft angle 0..359
//   i_clch_angle   in   9   clutched shaft angle 0..359, rest at 315
//   i_sccb         in   1   row-emitter contact
//   i_feed_req     in   1   level request for a feed cycle
//   i_hopper_empty in   1   blocks new cycles
//   i_stop_req     in   1   stop feeding after the current cycle
//   o_clch_latch   out  1   clutch latch magnet drive
//   o_busy         out  1   high in ARM or RUN
//   o_row_strobe   out  1   one-clk pulse per row contact during RUN
//   o_row_num      out  4   current row index 0..11
//   o_cycle_done   out  1   one-clk pulse at end of revolution
//   o_cycle_count  out 16   completed feed cycles, wrapping
//   o_fault        out  1   sticky engagement / row-count fault
// ============================================================================
module feed_cycle_ctrl #(
  parameter int ARM_WINDOW = 2,
  parameter int ROWS       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  i_cont_angle,
  input  logic [8:0]  i_clch_angle,
  input  logic        i_sccb,
  input  logic        i_feed_req,
  input  logic        i_hopper_empty,
  input  logic        i_stop_req,
  output logic        o_clch_latch,
  output logic        o_busy,
  output logic        o_row_strobe,
  output logic [3:0]  o_row_num,
  output logic        o_cycle_done,
  output logic [15:0] o_cycle_count,
  output logic        o_fault
);

  localparam int MW  = $clog2(ARM_WINDOW + 2);
  localparam int RCW = $clog2(ROWS + 2);
  localparam logic [MW-1:0]  MISS_LIM = MW'(ARM_WINDOW);
  localparam logic [RCW-1:0] ROWS_C   = RCW'(ROWS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_latch, w_latch_nxt;
  logic             r_fault, w_fault_nxt;
  logic [MW-1:0]    r_miss, w_miss_nxt;
  logic             r_stop_seen, w_stop_seen_nxt;
  logic             w_enter_run;

  logic             r_sccb_d;
  logic             r_row_strobe;
  logic [3:0]       r_row_num;
  logic [RCW-1:0]   r_rows;
  logic             r_cycle_done;
  logic [15:0]      r_cycle_count;

  logic w_at_rest;
  logic w_miss_pt;
  logic w_start;
  logic w_chain;
  logic w_sccb_rise;
  logic w_complete;
  logic w_row_err;

  assign w_at_rest = (i_clch_angle == 9'd315);

  // A miss is judged one degree after an engagement point: if the clutch had
  // caught, the clutched shaft would already have stepped off 315 by then.
`ifdef NONSYNC_EN
  assign w_miss_pt = (i_cont_angle == 9'd316) || (i_cont_angle == 9'd76) ||
                     (i_cont_angle == 9'd196);
`else
  assign w_miss_pt = (i_cont_angle == 9'd316);
`endif

  assign w_start     = i_feed_req && !i_hopper_empty && !i_stop_req && w_at_rest;
  // A stop request seen anywhere in the revolution blocks chaining at 314.
  assign w_chain     = i_feed_req && !i_hopper_empty && !i_stop_req && !r_stop_seen;
  assign w_sccb_rise = i_sccb && !r_sccb_d;
  assign w_complete  = (r_state == S_RUN) && w_at_rest;
  assign w_row_err   = (r_rows != ROWS_C);

  // State register and control flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_latch     <= 1'b0;
      r_fault     <= 1'b0;
      r_miss      <= '0;
      r_stop_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_latch     <= w_latch_nxt;
      r_fault     <= w_fault_nxt;
      r_miss      <= w_miss_nxt;
      r_stop_seen <= w_stop_seen_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt     = r_state;
    w_latch_nxt     = r_latch;
    w_fault_nxt     = r_fault;
    w_miss_nxt      = r_miss;
    w_stop_seen_nxt = r_stop_seen;
    w_enter_run     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_latch_nxt = 1'b0;
        if (w_start) begin
          w_state_nxt = S_ARM;
          w_latch_nxt = 1'b1;
          w_miss_nxt  = '0;
        end
      end
      S_ARM: begin
        // Once the shaft has left rest the clutch is committed, so departure
        // outranks a late stop or hopper-empty.
        if (!w_at_rest) begin
          w_state_nxt     = S_RUN;
          w_enter_run     = 1'b1;
          w_stop_seen_nxt = 1'b0;
        end else if (i_stop_req || i_hopper_empty) begin
          w_state_nxt = S_IDLE;
          w_latch_nxt = 1'b0;
        end else if (w_miss_pt) begin
          if (r_miss == MISS_LIM) begin
            w_state_nxt = S_HALT;
            w_fault_nxt = 1'b1;
            w_latch_nxt = 1'b0;
          end else begin
            w_miss_nxt = r_miss + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (i_stop_req) begin
          w_stop_seen_nxt = 1'b1;
        end
        if (w_at_rest) begin
          if (w_row_err) begin
            w_state_nxt = S_HALT;
            w_fault_nxt = 1'b1;
            w_latch_nxt = 1'b0;
          end else if (r_latch) begin
            // Chained: ARM moves on to RUN as soon as the shaft leaves rest.
            w_state_nxt = S_ARM;
            w_miss_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (i_clch_angle == 9'd314) begin
          w_latch_nxt = w_chain;
        end else begin
          w_latch_nxt = 1'b1;
        end
      end
      S_HALT: begin
        w_latch_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_latch_nxt = 1'b0;
      end
    endcase
  end

  // Row strobes, row counting and cycle bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sccb_d      <= 1'b0;
      r_row_strobe  <= 1'b0;
      r_row_num     <= 4'd0;
      r_rows        <= '0;
      r_cycle_done  <= 1'b0;
      r_cycle_count <= 16'd0;
    end else begin
      r_sccb_d     <= i_sccb;
      r_row_strobe <= (r_state == S_RUN) && w_sccb_rise;
      if (w_enter_run) begin
        r_row_num <= 4'd0;
        r_rows    <= '0;
      end else begin
        if (r_row_strobe && (r_row_num != 4'd11)) begin
          r_row_num <= r_row_num + 4'd1;
        end
        if ((r_state == S_RUN) && w_sccb_rise && (r_rows != '1)) begin
          r_rows <= r_rows + 1'b1;
        end
      end
      r_cycle_done <= w_complete;
      if (w_complete) begin
        r_cycle_count <= r_cycle_count + 16'd1;
      end
    end
  end

  assign o_clch_latch  = r_latch;
  assign o_busy        = (r_state == S_ARM) || (r_state == S_RUN);
  assign o_row_strobe  = r_row_strobe;
  assign o_row_num     = r_row_num;
  assign o_cycle_done  = r_cycle_done;
  assign o_cycle_count = r_cycle_count;
  assign o_fault       = r_fault;

endmodule
`default_nettype wire
